// File: rtl/pcie_cfg_pkg.sv
// rtl/pcie_cfg_pkg.sv - state encodings and default parameters for the PCIe config launcher
package pcie_cfg_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_STABLE = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_RETRY  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_FAIL   = 3'd6;

  localparam int DEF_LINK_STABLE_CYCLES = 1024;
  localparam int DEF_CFG_TIMEOUT_CYCLES = 1048576;
  localparam int DEF_RESET_CYCLES       = 16;
  localparam int DEF_MAX_RETRIES        = 3;
  localparam int DEF_CNT_WIDTH          = 21;
  localparam int DEF_RETRY_WIDTH        = 2;

endpackage

// File: rtl/pcie_cfg_launcher.sv
// rtl/pcie_cfg_launcher.sv - link-up qualified configurator launcher with watchdog and bounded retry
module pcie_cfg_launcher
  import pcie_cfg_pkg::*;
#(
  parameter int LINK_STABLE_CYCLES = DEF_LINK_STABLE_CYCLES,
  parameter int CFG_TIMEOUT_CYCLES = DEF_CFG_TIMEOUT_CYCLES,
  parameter int RESET_CYCLES       = DEF_RESET_CYCLES,
  parameter int MAX_RETRIES        = DEF_MAX_RETRIES,
  parameter int CNT_WIDTH          = DEF_CNT_WIDTH,
  parameter int RETRY_WIDTH        = DEF_RETRY_WIDTH
) (
  input  logic                   user_clk,
  input  logic                   reset,
  input  logic                   user_lnk_up,
  input  logic                   finished_config,
  input  logic                   failed_config,
  output logic                   start_config,
  output logic                   cfg_reset,
  output logic                   enum_done,
  output logic                   enum_failed,
  output logic [RETRY_WIDTH-1:0] retry_count,
  output logic [2:0]             launch_state
);

  localparam logic [CNT_WIDTH-1:0]   C_STABLE_LAST  = CNT_WIDTH'(LINK_STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]   C_TIMEOUT_LAST = CNT_WIDTH'(CFG_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]   C_RESET_LAST   = CNT_WIDTH'(RESET_CYCLES - 1);
  localparam logic [RETRY_WIDTH-1:0] C_MAX_RETRIES  = RETRY_WIDTH'(MAX_RETRIES);

  logic [2:0]             r_state;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [RETRY_WIDTH-1:0] r_retry;

  logic [2:0] w_next_state;
  logic       w_attempt_fail;
  logic       w_can_retry;

  assign w_attempt_fail = failed_config || (r_cnt == C_TIMEOUT_LAST);
  assign w_can_retry    = (r_retry < C_MAX_RETRIES);

  // Losing the link overrides everything, including a pending attempt result.
  always_comb begin
    w_next_state = r_state;
    if (r_state != ST_IDLE && !user_lnk_up) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (user_lnk_up) w_next_state = ST_STABLE;
        ST_STABLE: if (r_cnt == C_STABLE_LAST) w_next_state = ST_START;
        ST_START:  w_next_state = ST_WAIT;
        ST_WAIT: begin
          if (w_attempt_fail)       w_next_state = w_can_retry ? ST_RETRY : ST_FAIL;
          else if (finished_config) w_next_state = ST_DONE;
        end
        ST_RETRY:  if (r_cnt == C_RESET_LAST) w_next_state = ST_START;
        ST_DONE:   w_next_state = ST_DONE;
        ST_FAIL:   w_next_state = ST_FAIL;
        default:   w_next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge user_clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_retry <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_next_state != r_state) begin
        r_cnt <= '0;
      end else if (r_cnt != {CNT_WIDTH{1'b1}}) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_next_state == ST_IDLE) begin
        r_retry <= '0;
      end else if (r_state == ST_WAIT && w_next_state == ST_RETRY) begin
        r_retry <= r_retry + 1'b1;
      end
    end
  end

  assign start_config = (r_state == ST_START);
  assign cfg_reset    = (r_state == ST_IDLE) || (r_state == ST_STABLE) || (r_state == ST_RETRY);
  assign enum_done    = (r_state == ST_DONE);
  assign enum_failed  = (r_state == ST_FAIL);
  assign retry_count  = r_retry;
  assign launch_state = r_state;

endmodule

// File: tb/tb_pcie_cfg_launcher.sv
// tb/tb_pcie_cfg_launcher.sv - directed scoreboard bench for pcie_cfg_launcher
module tb_pcie_cfg_launcher;
  import pcie_cfg_pkg::*;

  localparam int L = 8;
  localparam int T = 64;
  localparam int R = 4;

  logic       user_clk = 1'b0;
  logic       reset;
  logic       user_lnk_up;
  logic       finished_config;
  logic       failed_config;
  logic       start_config;
  logic       cfg_reset;
  logic       enum_done;
  logic       enum_failed;
  logic [1:0] retry_count;
  logic [2:0] launch_state;

  int errors   = 0;
  int checks   = 0;
  int edge_cnt = 0;
  int n_starts = 0;
  int q_start[$];
  int s;
  int e;

  pcie_cfg_launcher #(
    .LINK_STABLE_CYCLES(L),
    .CFG_TIMEOUT_CYCLES(T),
    .RESET_CYCLES(R),
    .MAX_RETRIES(3),
    .CNT_WIDTH(7),
    .RETRY_WIDTH(2)
  ) dut (
    .user_clk(user_clk),
    .reset(reset),
    .user_lnk_up(user_lnk_up),
    .finished_config(finished_config),
    .failed_config(failed_config),
    .start_config(start_config),
    .cfg_reset(cfg_reset),
    .enum_done(enum_done),
    .enum_failed(enum_failed),
    .retry_count(retry_count),
    .launch_state(launch_state)
  );

  always #5 user_clk = ~user_clk;

  always @(posedge user_clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic run_to(input int target);
    while (edge_cnt < target) tick();
  endtask

  // Every start pulse is matched against the edge number pushed when the stimulus was driven.
  always @(negedge user_clk) begin
    if (start_config) begin
      int exp_edge;
      n_starts++;
      exp_edge = (q_start.size() != 0) ? q_start.pop_front() : -1;
      chk("start_edge", edge_cnt, exp_edge);
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; user_lnk_up = 1'b0; finished_config = 1'b0; failed_config = 1'b0;
    repeat (3) tick();
    chk("rst_state", launch_state, ST_IDLE);
    chk("rst_start", start_config, 0);
    chk("rst_cfg_reset", cfg_reset, 1);
    chk("rst_done", enum_done, 0);
    chk("rst_failed", enum_failed, 0);
    chk("rst_retry", retry_count, 0);
    reset = 1'b0;
    tick();
    chk("idle_no_link", launch_state, ST_IDLE);

    // clean bring-up
    user_lnk_up = 1'b1;
    s = edge_cnt + 1 + L;
    q_start.push_back(s);
    run_to(s);
    chk("clean_start", start_config, 1);
    chk("clean_cfg_reset_off", cfg_reset, 0);
    run_to(s + 9);
    finished_config = 1'b1;
    tick();
    finished_config = 1'b0;
    chk("clean_done", enum_done, 1);
    chk("clean_state", launch_state, ST_DONE);
    chk("clean_retry", retry_count, 0);
    tick();
    chk("clean_done_held", enum_done, 1);

    // link drop in DONE
    user_lnk_up = 1'b0;
    tick();
    chk("drop_state", launch_state, ST_IDLE);
    chk("drop_cfg_reset", cfg_reset, 1);
    chk("drop_done", enum_done, 0);
    chk("drop_retry", retry_count, 0);

    // link glitch during STABLE
    user_lnk_up = 1'b1;
    e = edge_cnt;
    run_to(e + 5);
    chk("glitch_stable", launch_state, ST_STABLE);
    user_lnk_up = 1'b0;
    tick();
    chk("glitch_idle", launch_state, ST_IDLE);
    tick();
    user_lnk_up = 1'b1;
    s = edge_cnt + 1 + L;
    q_start.push_back(s);
    run_to(s);
    chk("glitch_start", start_config, 1);

    // watchdog timeout then retry
    q_start.push_back(s + T + R + 1);
    run_to(s + T);
    chk("to_wait_last", launch_state, ST_WAIT);
    for (int k = s + T + 1; k <= s + T + R + 1; k++) begin
      tick();
      chk("to_cfg_reset", cfg_reset, (k <= s + T + R) ? 1 : 0);
    end
    chk("to_restart", start_config, 1);
    chk("to_retry", retry_count, 1);
    s = s + T + R + 1;
    run_to(s + 3);
    finished_config = 1'b1;
    tick();
    finished_config = 1'b0;
    chk("to_done", enum_done, 1);
    chk("to_done_retry", retry_count, 1);
    user_lnk_up = 1'b0;
    tick();
    chk("to_drop_retry", retry_count, 0);

    // simultaneous finish/fail, then exhaustion
    tick();
    user_lnk_up = 1'b1;
    s = edge_cnt + 1 + L;
    q_start.push_back(s);
    n_starts = 0;
    run_to(s + 1);
    finished_config = 1'b1;
    failed_config = 1'b1;
    tick();
    finished_config = 1'b0;
    failed_config = 1'b0;
    chk("both_state", launch_state, ST_RETRY);
    chk("both_done", enum_done, 0);
    chk("both_retry", retry_count, 1);
    for (int i = 1; i <= 3; i++) begin
      q_start.push_back(s + (R + 2) * i);
      run_to(s + (R + 2) * i + 1);
      failed_config = 1'b1;
      tick();
      failed_config = 1'b0;
      chk("exh_state", launch_state, (i < 3) ? ST_RETRY : ST_FAIL);
    end
    chk("exh_failed", enum_failed, 1);
    chk("exh_retry", retry_count, 3);
    chk("exh_starts", n_starts, 4);
    chk("exh_cfg_reset", cfg_reset, 0);
    repeat (10) tick();
    chk("exh_held", enum_failed, 1);

    // reset mid-WAIT
    user_lnk_up = 1'b0;
    tick();
    tick();
    user_lnk_up = 1'b1;
    s = edge_cnt + 1 + L;
    q_start.push_back(s);
    run_to(s + 5);
    chk("rw_wait", launch_state, ST_WAIT);
    reset = 1'b1;
    tick();
    chk("rw_state", launch_state, ST_IDLE);
    chk("rw_cfg_reset", cfg_reset, 1);
    chk("rw_done", enum_done, 0);
    chk("rw_retry", retry_count, 0);
    reset = 1'b0;
    user_lnk_up = 1'b0;
    repeat (3) tick();
    chk("sb_empty", q_start.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
